// File: rtl/zeroriscy_xbar_pkg.sv
// Shared types and constants for the zeroriscy system-port crossbar.
//   arb_state_e  : arbiter state (IDLE selects freely, LOCKED holds a
//                  master until its pending request is granted)
//   mid_t        : master identifier (0 = core data port, 1 = DMA)
//   OT_DEPTH_DEF : default number of granted-but-not-returned transfers
package zeroriscy_xbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic mid_t;

  localparam int OT_DEPTH_DEF = 2;

endpackage

// File: rtl/zeroriscy_id_fifo.sv
// Owner FIFO: remembers which master owns each outstanding transfer so
// responses can be routed back in order.
//   clk, reset : clock, asynchronous active-high reset
//   i_push     : write i_din (accepted when not full, or when popping)
//   i_pop      : drop head entry (ignored when empty)
//   i_din      : id to store
//   o_head     : id at the head of the queue
//   o_full     : count == DEPTH
//   o_empty    : count == 0
module zeroriscy_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/zeroriscy_ss_arb.sv
// Two-master arbiter in front of a single req/gnt/rvalid system port.
//   clk, reset            : clock, asynchronous active-high reset
//   m0_* / m1_*           : master request side (req, we, be, addr, wdata)
//                           and response side (gnt, rvalid, rdata)
//   s_*                   : system port request (req, we, be, addr, wdata)
//                           and response (gnt, rvalid, rdata)
//   proto_err             : sticky, set by s_rvalid with nothing outstanding
// Ties are broken round-robin; a request that is offered but not granted
// locks the selection so the system port sees a stable request.
module zeroriscy_ss_arb
  import zeroriscy_xbar_pkg::*;
#(
  parameter int OT_DEPTH = OT_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  output logic        proto_err
);

  arb_state_e r_state, w_state_nxt;
  mid_t       r_last_id, r_lock_id, w_sel_id, w_head;
  logic       w_sel_vld, w_sel_req, w_room, w_push, w_pop;
  logic       w_fifo_full, w_fifo_empty, r_proto_err;

  assign w_pop  = s_rvalid & ~w_fifo_empty;
  // A response retiring this cycle makes room for a new grant this cycle.
  assign w_room = ~w_fifo_full | w_pop;
  assign w_push = s_req & s_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_vld   = 1'b0;
    w_sel_id    = 1'b0;
    s_we        = 1'b0;
    s_be        = '0;
    s_addr      = '0;
    s_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          w_sel_vld = 1'b1;
          w_sel_id  = ~r_last_id;
        end else if (m0_req || m1_req) begin
          w_sel_vld = 1'b1;
          w_sel_id  = m1_req;
        end
      end
      LOCKED: begin
        w_sel_vld = 1'b1;
        w_sel_id  = r_lock_id;
      end
    endcase
    // Keep the system port quiet while reset is held, whatever the masters do.
    if (reset) w_sel_vld = 1'b0;

    w_sel_req = w_sel_vld & (w_sel_id ? m1_req : m0_req);
    s_req     = w_sel_req & w_room;
    m0_gnt    = s_req & s_gnt & ~w_sel_id;
    m1_gnt    = s_req & s_gnt &  w_sel_id;

    if (w_sel_vld) begin
      s_we    = w_sel_id ? m1_we    : m0_we;
      s_be    = w_sel_id ? m1_be    : m0_be;
      s_addr  = w_sel_id ? m1_addr  : m0_addr;
      s_wdata = w_sel_id ? m1_wdata : m0_wdata;
    end

    case (r_state)
      IDLE:   if (s_req && !s_gnt) w_state_nxt = LOCKED;
      // A locked master withdrawing its request is its own protocol
      // violation; release the lock rather than hang on it.
      LOCKED: if (!w_sel_req || (s_req && s_gnt)) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_id   <= 1'b1;
      r_lock_id   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_state_nxt == LOCKED) r_lock_id <= w_sel_id;
      if (w_push) r_last_id <= w_sel_id;
      if (s_rvalid && w_fifo_empty) r_proto_err <= 1'b1;
    end
  end

  zeroriscy_id_fifo #(
    .DEPTH (OT_DEPTH),
    .WIDTH (1)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_sel_id),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m0_rvalid = w_pop & ~w_head;
  assign m1_rvalid = w_pop &  w_head;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign proto_err = r_proto_err;

endmodule
